ss_scan_ctrl: RTL

- Upstream stage of the seven-segment display path: generates the digit-select scan sequence and supplies the four stable 3-bit digit values to the seven-segment driver.
- Uses a prescaler to set the per-digit refresh rate.
- Double-buffers incoming digit data so an update lands only at a frame boundary; no digit ever shows a mix of old and new data mid-frame.
- Provides a valid/ready load port toward the producing logic and a blank output that top level uses to gate the anode enables.

---
 rtl/ss_pkg.sv | 10 +
 rtl/ss_prescaler.sv | 50 +++++
 rtl/ss_scan_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared widths and digit type for the seven-segment scan path
package ss_pkg;

    localparam int DIGIT_W    = 3;
    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/ss_prescaler.sv
// rtl/ss_prescaler.sv - per-digit slot prescaler, phase output under SS_SCAN_DIM_EN
module ss_prescaler #(
    parameter int DIV = 100000,
    parameter int CW  = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef SS_SCAN_DIM_EN
    output logic [2:0] phase,
`endif
    output logic       tick
);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    // slot counter: runs 0..DIV-1 while enabled, holds while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

`ifdef SS_SCAN_DIM_EN
    logic [CW-1:0] sub_cnt;

    // eighth-of-slot phase counter, realigned to the slot start on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt <= '0;
            phase   <= '0;
        end else if (tick) begin
            sub_cnt <= '0;
            phase   <= '0;
        end else if (en) begin
            if (sub_cnt == CW'(DIV / 8 - 1)) begin
                sub_cnt <= '0;
                phase   <= phase + 3'd1;
            end else begin
                sub_cnt <= sub_cnt + CW'(1);
            end
        end
    end
`endif

endmodule

// File: rtl/ss_scan_ctrl.sv
// rtl/ss_scan_ctrl.sv - digit scan, double-buffered load and commit, optional SS_SCAN_DIM_EN dimming
module ss_scan_ctrl
    import ss_pkg::*;
#(
    parameter int DIV = 100000,
    parameter int CW  = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef SS_SCAN_DIM_EN
    input  logic [2:0]       duty,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  digit_t           din3,
    input  digit_t           din2,
    input  digit_t           din1,
    input  digit_t           din0,
    output digit_t           data3,
    output digit_t           data2,
    output digit_t           data1,
    output digit_t           data0,
    output logic [SEL_W-1:0] sel,
    output logic             blank,
    output logic             frame_done
);

    logic   tick;
    logic   frame_boundary;
    logic   accept;
    logic   pending;
    logic   blank_next;
    digit_t pend_buf [NUM_DIGITS];
    digit_t data_q   [NUM_DIGITS];

`ifdef SS_SCAN_DIM_EN
    logic [2:0] phase;

    ss_prescaler #(.DIV(DIV), .CW(CW)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .phase (phase),
        .tick  (tick)
    );

    assign blank_next = ~en | (phase > duty);
`else
    ss_prescaler #(.DIV(DIV), .CW(CW)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign blank_next = ~en;
`endif

    assign frame_boundary = tick && (sel == SEL_W'(NUM_DIGITS - 1));
    assign load_ready     = ~pending;
    assign accept         = load_valid && load_ready;

    assign data0 = data_q[0];
    assign data1 = data_q[1];
    assign data2 = data_q[2];
    assign data3 = data_q[3];

    // digit select advances once per slot and wraps after the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (tick) begin
            sel <= sel + SEL_W'(1);
        end
    end

    // capture offered data into the pending buffer; move it to the display only at a frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend_buf[i] <= '0;
                data_q[i]   <= '0;
            end
        end else if (accept) begin
            pending     <= 1'b1;
            pend_buf[0] <= din0;
            pend_buf[1] <= din1;
            pend_buf[2] <= din2;
            pend_buf[3] <= din3;
        end else if (frame_boundary && pending) begin
            pending <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                data_q[i] <= pend_buf[i];
            end
        end
    end

    // registered status toward the driver and top level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            blank      <= 1'b1;
        end else begin
            frame_done <= frame_boundary;
            blank      <= blank_next;
        end
    end

endmodule
